// File: rtl/led_pattern_ctrl.sv
// ---------------------------------------------------------------------------
// led_pattern_ctrl
//   Parametrised LED pattern generator. It drives a WIDTH-bit LED bank with
//   one of four patterns: rotate right, rotate left, bounce, or fill bar.
//   Patterns advance on an external step tick (clk_bps). A runtime divider
//   slows the pattern so that it moves once every (div+1) accepted ticks.
//
//   Optional macro LED_ACTIVE_LOW_EN: when defined, led is the inverted
//   pattern, for boards whose LEDs are active low. wrap and all timing are
//   the same whether or not the macro is defined.
//
// Ports
//   clk      in   1      system clock
//   rst_n    in   1      asynchronous reset, active low
//   clk_bps  in   1      step tick, one-cycle pulse synchronous to clk
//   en       in   1      1 = run, 0 = freeze pattern and divider
//   mode     in   2      0 SHR, 1 SHL, 2 BOUNCE, 3 FILL
//   div      in   DIV_W  pattern moves once every (div+1) accepted ticks
//   led      out  WIDTH  LED drive (comes from a register)
//   wrap     out  1      one-cycle pulse when a pattern period completes
// ---------------------------------------------------------------------------
module led_pattern_ctrl #(
    parameter int WIDTH = 8,
    parameter int DIV_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clk_bps,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [DIV_W-1:0] div,
    output logic [WIDTH-1:0] led,
    output logic             wrap
);

    typedef enum logic [1:0] {M_SHR, M_SHL, M_BOUNCE, M_FILL} mode_e;
    typedef enum logic {DIR_RIGHT, DIR_LEFT} dir_e;

    localparam logic [WIDTH-1:0] MSB_HOT  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] LSB_HOT  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

    logic [WIDTH-1:0] pattern_q, pattern_d;
    logic [DIV_W-1:0] tick_cnt_q, tick_cnt_d;
    mode_e            mode_q, mode_d;
    dir_e             dir_q, dir_d;
    logic             wrap_q, wrap_d;

    mode_e mode_in;
    logic  mode_chg;
    logic  accept;

    assign mode_in  = mode_e'(mode);
    assign mode_chg = (mode_in != mode_q);
    assign accept   = clk_bps && en;

    function automatic logic [WIDTH-1:0] start_pattern(input mode_e m);
        case (m)
            M_SHL:   start_pattern = LSB_HOT;
            M_FILL:  start_pattern = '0;
            default: start_pattern = MSB_HOT;
        endcase
    endfunction

    always_comb begin
        pattern_d  = pattern_q;
        tick_cnt_d = tick_cnt_q;
        dir_d      = dir_q;
        wrap_d     = 1'b0;
        mode_d     = mode_in;

        if (mode_chg) begin
            // A reload wins over a move on the same edge, and it never pulses wrap.
            pattern_d  = start_pattern(mode_in);
            tick_cnt_d = '0;
            dir_d      = DIR_RIGHT;
        end else if (accept) begin
            // >= rather than == keeps the divider from running away when
            // div is lowered below the current count.
            if (tick_cnt_q >= div) begin
                tick_cnt_d = '0;
                case (mode_q)
                    M_SHR: begin
                        if (pattern_q == LSB_HOT) begin
                            pattern_d = MSB_HOT;
                            wrap_d    = 1'b1;
                        end else begin
                            pattern_d = pattern_q >> 1;
                        end
                    end
                    M_SHL: begin
                        if (pattern_q == MSB_HOT) begin
                            pattern_d = LSB_HOT;
                            wrap_d    = 1'b1;
                        end else begin
                            pattern_d = pattern_q << 1;
                        end
                    end
                    M_BOUNCE: begin
                        // The direction flips on the move that lands on an end,
                        // so each end LED is lit for only one step.
                        if (dir_q == DIR_RIGHT) begin
                            pattern_d = pattern_q >> 1;
                            if (pattern_d == LSB_HOT) dir_d = DIR_LEFT;
                        end else begin
                            pattern_d = pattern_q << 1;
                            if (pattern_d == MSB_HOT) begin
                                dir_d  = DIR_RIGHT;
                                wrap_d = 1'b1;
                            end
                        end
                    end
                    default: begin
                        if (pattern_q == ALL_ONES) begin
                            pattern_d = '0;
                            wrap_d    = 1'b1;
                        end else begin
                            pattern_d = {1'b1, pattern_q[WIDTH-1:1]};
                        end
                    end
                endcase
            end else begin
                tick_cnt_d = tick_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pattern_q  <= MSB_HOT;
            tick_cnt_q <= '0;
            mode_q     <= M_SHR;
            dir_q      <= DIR_RIGHT;
            wrap_q     <= 1'b0;
        end else begin
            pattern_q  <= pattern_d;
            tick_cnt_q <= tick_cnt_d;
            mode_q     <= mode_d;
            dir_q      <= dir_d;
            wrap_q     <= wrap_d;
        end
    end

`ifdef LED_ACTIVE_LOW_EN
    assign led = ~pattern_q;
`else
    assign led = pattern_q;
`endif
    assign wrap = wrap_q;

endmodule

// File: tb/tb_led_pattern_ctrl.sv
module tb_led_pattern_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clk_bps;
    logic       en;
    logic [1:0] mode;
    logic [3:0] div;
    logic [7:0] led;
    logic       wrap;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       bps;
        logic       en;
        logic [1:0] mode;
        logic [3:0] div;
        logic [7:0] pat;
        logic       wrap;
    } vec_t;

    vec_t vecs[$];

    led_pattern_ctrl #(.WIDTH(8), .DIV_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .clk_bps(clk_bps), .en(en),
        .mode(mode), .div(div), .led(led), .wrap(wrap)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] led_of(input logic [7:0] pat);
`ifdef LED_ACTIVE_LOW_EN
        return ~pat;
`else
        return pat;
`endif
    endfunction

    task automatic check(input string name, input int idx, input logic [7:0] exp_pat,
                         input logic exp_wrap);
        checks++;
        if (led !== led_of(exp_pat) || wrap !== exp_wrap) begin
            errors++;
            $display("FAIL %s[%0d] led got %h want %h, wrap got %b want %b",
                     name, idx, led, led_of(exp_pat), wrap, exp_wrap);
        end
    endtask

    task automatic add(input logic b, input logic e, input logic [1:0] m, input logic [3:0] d,
                       input logic [7:0] p, input logic w);
        vec_t v;
        v.bps = b; v.en = e; v.mode = m; v.div = d; v.pat = p; v.wrap = w;
        vecs.push_back(v);
    endtask

    task automatic add_seq(input logic [1:0] m, input logic [3:0] d, input logic [7:0] pats[],
                           input int wrap_at);
        foreach (pats[i]) add(1'b1, 1'b1, m, d, pats[i], (i == wrap_at));
    endtask

    initial begin
        logic [7:0] s1[], s2[], s3[], s4[], s5[];

        // Test 1: SHR through one period
        s1 = '{8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h80};
        add_seq(2'd0, 4'd0, s1, 7);
        add(1'b0, 1'b1, 2'd0, 4'd0, 8'h80, 1'b0);           // wrap lasts one cycle
        // Test 2: BOUNCE; reload cycle, then a full period
        add(1'b0, 1'b1, 2'd2, 4'd0, 8'h80, 1'b0);
        s2 = '{8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01,
               8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
        add_seq(2'd2, 4'd0, s2, 13);
        add(1'b0, 1'b1, 2'd2, 4'd0, 8'h80, 1'b0);
        // Test 3: FILL; the reload arrives with a tick, and the reload wins
        add(1'b1, 1'b1, 2'd3, 4'd0, 8'h00, 1'b0);
        s3 = '{8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF, 8'h00};
        add_seq(2'd3, 4'd0, s3, 8);
        // Test 4: div=2, moves on ticks 3, 6 and 9
        s4 = '{8'h00, 8'h00, 8'h80, 8'h80, 8'h80, 8'hC0, 8'hC0, 8'hC0, 8'hE0};
        add_seq(2'd3, 4'd2, s4, -1);
        for (int i = 0; i < 5; i++) add(1'b1, 1'b0, 2'd3, 4'd2, 8'hE0, 1'b0);  // frozen
        add(1'b1, 1'b1, 2'd3, 4'd2, 8'hE0, 1'b0);           // count 0 -> 1 (it was held)
        add(1'b1, 1'b1, 2'd3, 4'd2, 8'hE0, 1'b0);           // count 1 -> 2
        add(1'b1, 1'b1, 2'd3, 4'd2, 8'hF0, 1'b0);           // move
        add(1'b1, 1'b1, 2'd3, 4'd2, 8'hF0, 1'b0);           // count 1
        add(1'b1, 1'b1, 2'd3, 4'd0, 8'hF8, 1'b0);           // div lowered under count: move
        add(1'b0, 1'b1, 2'd3, 4'd0, 8'hF8, 1'b0);           // no tick: hold
        // Test 5: SHR to 08, then switch to SHL together with a tick
        add(1'b0, 1'b1, 2'd0, 4'd0, 8'h80, 1'b0);
        s5 = '{8'h40, 8'h20, 8'h10, 8'h08};
        add_seq(2'd0, 4'd0, s5, -1);
        add(1'b1, 1'b1, 2'd1, 4'd0, 8'h01, 1'b0);
        s5 = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
        add_seq(2'd1, 4'd0, s5, 7);
        add(1'b0, 1'b1, 2'd1, 4'd0, 8'h01, 1'b0);

        // Reset state
        rst_n = 1'b0; clk_bps = 1'b0; en = 1'b1; mode = 2'd0; div = 4'd0;
        #12;
        check("reset", 0, 8'h80, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            clk_bps = vecs[i].bps; en = vecs[i].en; mode = vecs[i].mode; div = vecs[i].div;
            @(posedge clk); #1;
            check("vec", i, vecs[i].pat, vecs[i].wrap);
            @(negedge clk);
        end

        // Test 6: asynchronous reset between edges, in the middle of the SHL run
        clk_bps = 1'b1; en = 1'b1; mode = 2'd1; div = 4'd0;
        @(posedge clk); #1;
        check("pre_rst", 0, 8'h02, 1'b0);
        #2 rst_n = 1'b0;
        #1 check("async_rst", 0, 8'h80, 1'b0);
        @(posedge clk); #1;
        check("rst_hold", 0, 8'h80, 1'b0);
        // When mode is nonzero coming out of reset, the first edge reloads
        clk_bps = 1'b0; mode = 2'd3;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_reload", 0, 8'h00, 1'b0);
        clk_bps = 1'b1;
        @(posedge clk); #1;
        check("rst_reload", 1, 8'h80, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
